// File: rtl/pc_unit.sv
// Program counter and fetch sequencer: fetches over a req/ack handshake, latches the
// instruction, then selects the next PC from sequential, branch, jump or register targets.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [15:0] Imm16,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] RegAddr,
    input  logic        Stall,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StTrap
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        misalign_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{Imm16[15]}}, Imm16, 2'b00};
        next_pc    = pc_plus4;
        if (JumpReg) begin
            next_pc = RegAddr;
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], JumpIndex, 2'b00};
        end else if (PCSrc) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (ImemAck) begin
                        instr_q <= ImemRdata;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (!Stall) begin
                        // Only a jr target can be misaligned; PC stays on the faulting instruction.
                        if (next_pc[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state_q    <= StTrap;
                        end else begin
                            pc_q    <= next_pc;
                            state_q <= StFetch;
                        end
                    end
                end
                StTrap: state_q <= StTrap;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ImemReq     = (state_q == StFetch);
    assign InstrValid  = (state_q == StExec);
    assign ImemAddr    = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign Instr       = instr_q;
    assign MisalignErr = misalign_q;

endmodule
